mem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency synchronous memory between the core's instruction-fetch requester and its data requester.
- Replaces the dual-port combinational memory path. Issues one access at a time and returns read data or a write acknowledge.
- Generates the core stall used to freeze PC while an access is outstanding.
- Fixed priority favours data, with a starvation counter that guarantees forward progress for instruction fetch.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one fixed-latency synchronous memory port between
//                    instruction fetch and data access, with core stall.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  logic             owner_d;
  logic             acc_we;
  logic [LAT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;
  logic             grant_d;
  logic             grant_i;

  // Data wins ties unless instruction fetch has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant_d = d_req & (~i_req | (starve_cnt != STV_LIMIT));
    grant_i = i_req & ~grant_d;
  end

  assign stall = (i_req & ~i_valid) | (d_req & ~d_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      acc_we     <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            owner_d  <= grant_d;
            acc_we   <= grant_d & d_we;
            mem_en   <= 1'b1;
            mem_we   <= grant_d & d_we;
            mem_addr <= grant_d ? d_addr : i_addr;
            if (grant_d) begin
              mem_wdata <= d_wdata;
            end
            if (grant_i) begin
              starve_cnt <= '0;
            end else if (i_req && (starve_cnt != STV_LIMIT)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            // Writes leave both read-data registers untouched.
            if (!acc_we) begin
              if (owner_d) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
            d_valid <= owner_d;
            i_valid <= ~owner_d;
            state   <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : four arbiters (MEM_LATENCY 1..4) on a shared memory
//                       model, checked through a response scoreboard.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int NU = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_mem;
  logic        i_req     [NU];
  logic [31:0] i_addr    [NU];
  logic [31:0] i_rdata   [NU];
  logic        i_valid   [NU];
  logic        d_req     [NU];
  logic        d_we      [NU];
  logic [31:0] d_addr    [NU];
  logic [31:0] d_wdata   [NU];
  logic [31:0] d_rdata   [NU];
  logic        d_valid   [NU];
  logic        mem_en    [NU];
  logic        mem_we    [NU];
  logic [31:0] mem_addr  [NU];
  logic [31:0] mem_wdata [NU];
  logic [31:0] mem_rdata [NU];
  logic        stall     [NU];

  logic [31:0] mem [256];
  logic [31:0] pd  [NU][NU];
  logic        pv  [NU][NU];

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          u;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          u;
    bit          is_d;
    bit          we;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .MEM_LATENCY (g + 1),
      .STARVE_LIMIT(4)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_rdata  (i_rdata[g]),
      .i_valid  (i_valid[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_valid  (d_valid[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .stall    (stall[g])
    );
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 124) return 32'h8C08_0004;
    return 32'h5A00_0000 + (32'(i) * 32'h0001_0101);
  endfunction

  // Memory model: unit k returns read data exactly k+1 cycles after mem_en.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      for (int k = 0; k < NU; k++)
        if (mem_en[k] && mem_we[k]) mem[mem_addr[k][7:0]] <= mem_wdata[k];
    end
    for (int k = 0; k < NU; k++) begin
      pv[k][0] <= mem_en[k] && !mem_we[k];
      pd[k][0] <= mem[mem_addr[k][7:0]];
      for (int j = 1; j < NU; j++) begin
        pv[k][j] <= pv[k][j-1];
        pd[k][j] <= pd[k][j-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NU; k++) mem_rdata[k] = pv[k][k] ? pd[k][k] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NU; k++) begin
      if (mem_we[k]) chk("we_needs_en", 64'(mem_en[k]), 64'd1);
      if (i_valid[k] || d_valid[k]) begin
        chk("one_valid", 64'(i_valid[k] & d_valid[k]), 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(sb.size()), 64'd1);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_unit", 64'(k), 64'(e.u));
          chk("sb_port", 64'(d_valid[k]), 64'(e.is_d));
          if (!e.we) chk("sb_rdata", 64'(d_valid[k] ? d_rdata[k] : i_rdata[k]), 64'(e.exp));
        end
      end
    end
  end

  task automatic push(input int u, input bit is_d, input bit we, input logic [31:0] exp);
    sb_t e;
    e.u = u; e.is_d = is_d; e.we = we; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    chk(nm, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Single isolated access; called just after a rising edge with the unit idle.
  task automatic run_vec(input vec_t v);
    int          t0;
    int          en_cnt;
    bit          got;
    logic [31:0] prev_d;
    en_cnt = 0;
    got    = 0;
    prev_d = d_rdata[v.u];
    push(v.u, v.is_d, v.we, v.exp);
    if (v.is_d) begin
      d_req[v.u] = 1'b1; d_we[v.u] = v.we; d_addr[v.u] = v.addr; d_wdata[v.u] = v.wdata;
    end else begin
      i_req[v.u] = 1'b1; i_addr[v.u] = v.addr;
    end
    t0 = cyc;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (mem_en[v.u]) begin
        en_cnt++;
        chk("en_cycle", 64'(cyc - t0), 64'd1);
        chk("mem_we", 64'(mem_we[v.u]), 64'(v.is_d & v.we));
        chk("mem_addr", 64'(mem_addr[v.u]), 64'(v.addr));
        if (v.is_d && v.we) chk("mem_wdata", 64'(mem_wdata[v.u]), 64'(v.wdata));
      end
      if (i_valid[v.u] || d_valid[v.u]) begin
        got = 1;
        chk("latency", 64'(cyc - t0), 64'(v.u + 3));
        chk("stall_resp", 64'(stall[v.u]), 64'd0);
        chk("en_count", 64'(en_cnt), 64'd1);
        if (v.is_d && v.we) chk("rdata_hold", 64'(d_rdata[v.u]), 64'(prev_d));
      end else begin
        chk("stall_wait", 64'(stall[v.u]), 64'd1);
      end
    end
    if (!got) chk("timeout", 64'd0, 64'd1);
    i_req[v.u] = 1'b0;
    d_req[v.u] = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs[12];

  initial begin
    int  t0;
    int  ndata;
    bit  done;
    vecs[0]  = '{0, 1'b0, 1'b0, 32'd124,        32'd0,         32'h8C08_0004};
    vecs[1]  = '{0, 1'b1, 1'b1, 32'd10,         32'hDEAD_BEEF, 32'd0};
    vecs[2]  = '{0, 1'b1, 1'b0, 32'd10,         32'd0,         32'hDEAD_BEEF};
    vecs[3]  = '{0, 1'b0, 1'b0, 32'd10,         32'd0,         32'hDEAD_BEEF};
    vecs[4]  = '{1, 1'b1, 1'b1, 32'd33,         32'h1234_5678, 32'd0};
    vecs[5]  = '{1, 1'b1, 1'b0, 32'd33,         32'd0,         32'h1234_5678};
    vecs[6]  = '{1, 1'b0, 1'b0, 32'd7,          32'd0,         init_word(7)};
    vecs[7]  = '{2, 1'b0, 1'b0, 32'hFFFF_FF7C,  32'd0,         32'h8C08_0004};
    vecs[8]  = '{3, 1'b1, 1'b1, 32'd200,        32'hA5A5_5A5A, 32'd0};
    vecs[9]  = '{3, 1'b1, 1'b0, 32'd200,        32'd0,         32'hA5A5_5A5A};
    vecs[10] = '{3, 1'b0, 1'b0, 32'd3,          32'd0,         init_word(3)};
    vecs[11] = '{2, 1'b1, 1'b0, 32'd99,         32'd0,         init_word(99)};

    for (int k = 0; k < NU; k++) begin
      i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
    end
    reset    = 1'b1;
    load_mem = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NU; k++) begin
      chk("rst_outs", 64'({i_valid[k], d_valid[k], mem_en[k], mem_we[k], stall[k]}), 64'd0);
      chk("rst_data", 64'(mem_addr[k] | mem_wdata[k] | i_rdata[k] | d_rdata[k]), 64'd0);
    end
    load_mem = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);
    drain("sb_table");

    // Simultaneous requests on unit 0: data first, instruction in the next IDLE.
    push(0, 1'b1, 1'b0, init_word(20));
    push(0, 1'b0, 1'b0, init_word(5));
    i_req[0] = 1'b1; i_addr[0] = 32'd5;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'd20;
    t0   = cyc;
    done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (d_valid[0]) begin
        chk("both_d_lat", 64'(cyc - t0), 64'd3);
        chk("both_stall", 64'(stall[0]), 64'd1);
        d_req[0] = 1'b0;
      end
      if (i_valid[0]) begin
        chk("both_i_lat", 64'(cyc - t0), 64'd7);
        chk("both_stall_i", 64'(stall[0]), 64'd0);
        done = 1;
      end
    end
    if (!done) chk("both_timeout", 64'd0, 64'd1);
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    @(posedge clk); #1;
    drain("sb_both");

    // Two starvation rounds: the second also needs four data wins first,
    // which only holds if the counter cleared on the instruction grant.
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) push(0, 1'b1, 1'b0, init_word(40 + 10 * r + j));
      push(0, 1'b0, 1'b0, init_word(5));
      i_req[0] = 1'b1; i_addr[0] = 32'd5;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'(40 + 10 * r);
      ndata = 0;
      done  = 0;
      for (int n = 0; n < 100 && !done; n++) begin
        @(negedge clk);
        if (d_valid[0]) begin
          ndata++;
          d_addr[0] = 32'(40 + 10 * r + ndata);
        end
        if (i_valid[0]) begin
          chk("starve_grants", 64'(ndata), 64'd4);
          done = 1;
        end
      end
      if (!done) chk("starve_timeout", 64'd0, 64'd1);
      i_req[0] = 1'b0; d_req[0] = 1'b0;
      @(posedge clk); #1;
      drain("sb_starve");
    end

    // Reset while unit 2 (latency 3) is in WAIT: the access is dropped.
    i_req[2] = 1'b1; i_addr[2] = 32'd124;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_outs", 64'({i_valid[2], d_valid[2], mem_en[2], mem_we[2]}), 64'd0);
    chk("midrst_data", 64'(mem_addr[2] | mem_wdata[2] | i_rdata[2] | d_rdata[2]), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec('{2, 1'b0, 1'b0, 32'd124, 32'd0, 32'h8C08_0004});
    drain("sb_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
